// File: rtl/gtf_ctrl_pkg.sv
// Shared state codes, widths and parameter checks
// for the GTF link bring-up controller.
package gtf_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RST  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_QUAL = 3'd3;
  localparam logic [2:0] ST_UP   = 3'd4;
  localparam logic [2:0] ST_FAIL = 3'd5;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 16;

  // True when every interval fits an unsigned timer of cnt_w bits.
  function automatic bit cnt_fits(
    input int     cnt_w,
    input longint a,
    input longint b,
    input longint c
  );
    longint lim;
    lim = longint'(1) << cnt_w;
    return (a < lim) && (b < lim) && (c < lim);
  endfunction

endpackage

// File: rtl/syncer_level.sv
// Multi-flop level synchronizer with
// active-low async reset and a reset value.
module syncer_level #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/gtf_link_bringup_ctrl.sv
// GTF channel bring-up sequencer: reset hold,
// link wait with timeout, stability qualify, retry.
module gtf_link_bringup_ctrl
  import gtf_ctrl_pkg::*;
#(
  parameter int          RESET_CYCLES  = 100,
  parameter logic [31:0] LINK_TIMEOUT  = 32'h0100_0000,
  parameter int          STABLE_CYCLES = 2048,
  parameter int          MAX_RETRY     = 7,
  parameter int          CNT_W         = 32
) (
  input  logic              gtf_freerun_clk,
  input  logic              gtf_sys_rst,
  input  logic              gtf_clk_wiz_locked,
  input  logic              link_status_in,
  input  logic              ctl_enable,
  input  logic              fail_clear,
  output logic              hb_gtwiz_reset_all_out,
  output logic              link_stable,
  output logic              ctl_hwchk_frm_gen_en_out,
  output logic              ctl_hwchk_mon_en_out,
  output logic [2:0]        ctrl_state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0] link_loss_cnt,
  output logic              bringup_fail
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LINK_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRY);

  if (!cnt_fits(CNT_W, longint'(RESET_CYCLES),
                longint'(LINK_TIMEOUT),
                longint'(STABLE_CYCLES))) begin : g_cnt_w_bad
    $error("CNT_W too narrow for configured intervals");
  end

  logic w_rst_n;
  logic w_locked_s;
  logic w_link_s;

  assign w_rst_n = ~gtf_sys_rst;

  syncer_level #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_sync_lock (
    .clk   (gtf_freerun_clk),
    .rst_n (w_rst_n),
    .d     (gtf_clk_wiz_locked),
    .q     (w_locked_s)
  );

  syncer_level #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_sync_link (
    .clk   (gtf_freerun_clk),
    .rst_n (w_rst_n),
    .d     (link_status_in),
    .q     (w_link_s)
  );

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_timer;
  logic [RETRY_W-1:0] r_retry;
  logic [LOSS_W-1:0]  r_loss_cnt;
  logic               r_rst_all;
  logic               r_up;
  logic               r_fail;

  logic [2:0]         w_nxt_state;
  logic [CNT_W-1:0]   w_nxt_timer;
  logic [RETRY_W-1:0] w_nxt_retry;
  logic [LOSS_W-1:0]  w_nxt_loss;
  logic               w_att_fail;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_retry = r_retry;
    w_nxt_loss  = r_loss_cnt;
    w_att_fail  = 1'b0;

    // Lock/enable drop overrides everything except a latched failure.
    if (r_state != ST_FAIL && (!w_locked_s || !ctl_enable)) begin
      w_nxt_state = ST_IDLE;
      w_nxt_timer = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_nxt_state = ST_RST;
          w_nxt_retry = '0;
          w_nxt_timer = '0;
        end
        ST_RST: begin
          if (r_timer == RST_LAST) begin
            w_nxt_state = ST_WAIT;
            w_nxt_timer = '0;
          end else begin
            w_nxt_timer = r_timer + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (w_link_s) begin
            w_nxt_state = ST_QUAL;
            w_nxt_timer = '0;
          end else if (r_timer == TMO_LAST) begin
            w_att_fail = 1'b1;
          end else begin
            w_nxt_timer = r_timer + CNT_W'(1);
          end
        end
        ST_QUAL: begin
          if (!w_link_s) begin
            w_att_fail = 1'b1;
          end else if (r_timer == STB_LAST) begin
            w_nxt_state = ST_UP;
            w_nxt_retry = '0;
            w_nxt_timer = '0;
          end else begin
            w_nxt_timer = r_timer + CNT_W'(1);
          end
        end
        ST_UP: begin
          if (!w_link_s) begin
            w_nxt_state = ST_RST;
            w_nxt_timer = '0;
            if (r_loss_cnt != '1)
              w_nxt_loss = r_loss_cnt + LOSS_W'(1);
          end
        end
        ST_FAIL: begin
          if (fail_clear) begin
            w_nxt_state = ST_IDLE;
            w_nxt_retry = '0;
            w_nxt_timer = '0;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_timer = '0;
        end
      endcase
    end

    if (w_att_fail) begin
      w_nxt_timer = '0;
      if (r_retry == RETRY_MAX) begin
        w_nxt_state = ST_FAIL;
      end else begin
        w_nxt_state = ST_RST;
        w_nxt_retry = r_retry + RETRY_W'(1);
      end
    end
  end

  always_ff @(posedge gtf_freerun_clk or posedge gtf_sys_rst) begin
    if (gtf_sys_rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_retry    <= '0;
      r_loss_cnt <= '0;
      r_rst_all  <= 1'b1;
      r_up       <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_timer    <= w_nxt_timer;
      r_retry    <= w_nxt_retry;
      r_loss_cnt <= w_nxt_loss;
      r_rst_all  <= (w_nxt_state == ST_IDLE) ||
                    (w_nxt_state == ST_RST)  ||
                    (w_nxt_state == ST_FAIL);
      r_up       <= (w_nxt_state == ST_UP);
      r_fail     <= (w_nxt_state == ST_FAIL);
    end
  end

  assign hb_gtwiz_reset_all_out   = r_rst_all;
  assign link_stable              = r_up;
  assign ctl_hwchk_frm_gen_en_out = r_up;
  assign ctl_hwchk_mon_en_out     = r_up;
  assign ctrl_state               = r_state;
  assign retry_cnt                = r_retry;
  assign link_loss_cnt            = r_loss_cnt;
  assign bringup_fail             = r_fail;

endmodule

// File: tb/tb_gtf_link_bringup_ctrl.sv
// Directed bench for gtf_link_bringup_ctrl with
// RESET_CYCLES=4, LINK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRY=2.
`timescale 1ns/1ps
module tb_gtf_link_bringup_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic        link;
  logic        en;
  logic        fclr;
  logic        rst_all;
  logic        stable;
  logic        gen_en;
  logic        mon_en;
  logic [2:0]  state;
  logic [3:0]  retry;
  logic [15:0] loss;
  logic        bfail;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gtf_link_bringup_ctrl #(
    .RESET_CYCLES  (4),
    .LINK_TIMEOUT  (32'd16),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .CNT_W         (32)
  ) dut (
    .gtf_freerun_clk          (clk),
    .gtf_sys_rst              (rst),
    .gtf_clk_wiz_locked       (lock),
    .link_status_in           (link),
    .ctl_enable               (en),
    .fail_clear               (fclr),
    .hb_gtwiz_reset_all_out   (rst_all),
    .link_stable              (stable),
    .ctl_hwchk_frm_gen_en_out (gen_en),
    .ctl_hwchk_mon_en_out     (mon_en),
    .ctrl_state               (state),
    .retry_cnt                (retry),
    .link_loss_cnt            (loss),
    .bringup_fail             (bfail)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_en(input string tag, input logic exp);
    chk(tag, {29'd0, stable, gen_en, mon_en},
        {29'd0, {3{exp}}});
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    link = 1'b0;
    en   = 1'b0;
    fclr = 1'b0;
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_resetall", rst_all, 1'b1);
    chk_en("rst_enables", 1'b0);
    chk("rst_retry", retry, 4'd0);
    chk("rst_loss", loss, 16'd0);
    chk("rst_bfail", bfail, 1'b0);
    tick(2);

    rst  = 1'b0;
    lock = 1'b1;
    en   = 1'b1;
    tick(2);
    chk("nom_idle_sync", state, 3'd0);
    tick(1);
    chk("nom_rst_entry", state, 3'd1);
    chk("nom_rst_hi", rst_all, 1'b1);
    tick(3);
    chk("nom_rst_dwell", state, 3'd1);
    chk("nom_rst_hi3", rst_all, 1'b1);
    tick(1);
    chk("nom_wait", state, 3'd2);
    chk("nom_wait_rstlo", rst_all, 1'b0);
    tick(5);
    link = 1'b1;
    tick(2);
    chk("nom_wait_sync", state, 3'd2);
    tick(1);
    chk("nom_qual", state, 3'd3);
    tick(7);
    chk("nom_qual7", state, 3'd3);
    chk_en("nom_qual_en", 1'b0);
    tick(1);
    chk("nom_up", state, 3'd4);
    chk_en("nom_up_en", 1'b1);
    chk("nom_up_retry", retry, 4'd0);
    chk("nom_up_rstlo", rst_all, 1'b0);

    link = 1'b0;
    tick(2);
    chk("loss_still_up", state, 3'd4);
    tick(1);
    chk("loss_rst", state, 3'd1);
    chk("loss_cnt1", loss, 16'd1);
    chk("loss_retry", retry, 4'd0);
    chk_en("loss_en", 1'b0);
    link = 1'b1;
    tick(12);
    chk("loss_requal", state, 3'd3);
    tick(1);
    chk("loss_reup", state, 3'd4);
    force dut.r_loss_cnt = 16'hFFFF;
    #1;
    release dut.r_loss_cnt;
    chk("sat_preset", loss, 16'hFFFF);
    link = 1'b0;
    tick(3);
    chk("sat_rst", state, 3'd1);
    chk("sat_hold", loss, 16'hFFFF);

    tick(4);
    chk("flap_wait", state, 3'd2);
    link = 1'b1;
    tick(3);
    chk("flap_qual", state, 3'd3);
    tick(4);
    link = 1'b0;
    tick(2);
    chk("flap_qual_hold", state, 3'd3);
    chk_en("flap_en_q", 1'b0);
    tick(1);
    chk("flap_rst", state, 3'd1);
    chk("flap_retry", retry, 4'd1);
    chk_en("flap_en_r", 1'b0);

    link = 1'b1;
    tick(4);
    chk("lk_wait", state, 3'd2);
    tick(1);
    chk("lk_qual", state, 3'd3);
    tick(2);
    lock = 1'b0;
    tick(2);
    chk("lk_qual_hold", state, 3'd3);
    tick(1);
    chk("lk_idle", state, 3'd0);
    chk("lk_idle_rst", rst_all, 1'b1);
    chk_en("lk_idle_en", 1'b0);
    chk("lk_retry_kept", retry, 4'd1);
    lock = 1'b1;
    tick(2);
    chk("lk_idle_sync", state, 3'd0);
    tick(1);
    chk("lk_rst", state, 3'd1);
    chk("lk_retry_clr", retry, 4'd0);
    tick(3);
    chk("lk_rst3", state, 3'd1);
    tick(1);
    chk("lk_wait2", state, 3'd2);
    tick(1);
    chk("lk_qual2", state, 3'd3);
    tick(8);
    chk("lk_up", state, 3'd4);

    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", state, 3'd0);
    chk("ar_resetall", rst_all, 1'b1);
    chk("ar_loss", loss, 16'd0);
    chk_en("ar_en", 1'b0);
    link = 1'b0;
    #2;
    rst = 1'b0;

    tick(2);
    chk("to_idle", state, 3'd0);
    tick(1);
    chk("to_rst0", state, 3'd1);
    chk("to_retry0", retry, 4'd0);
    tick(19);
    fclr = 1'b1;
    chk("to_wait0_end", state, 3'd2);
    tick(1);
    fclr = 1'b0;
    chk("to_rst1", state, 3'd1);
    chk("to_retry1", retry, 4'd1);
    tick(19);
    chk("to_wait1_end", state, 3'd2);
    tick(1);
    chk("to_rst2", state, 3'd1);
    chk("to_retry2", retry, 4'd2);
    tick(19);
    chk("to_wait2_end", state, 3'd2);
    chk("to_nofail", bfail, 1'b0);
    tick(1);
    chk("to_fail", state, 3'd5);
    chk("to_bfail", bfail, 1'b1);
    chk("to_fail_rst", rst_all, 1'b1);
    chk("to_fail_retry", retry, 4'd2);
    en   = 1'b0;
    lock = 1'b0;
    tick(4);
    chk("fail_sticky", state, 3'd5);
    en   = 1'b1;
    lock = 1'b1;
    tick(3);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    chk("clr_idle", state, 3'd0);
    chk("clr_bfail", bfail, 1'b0);
    chk("clr_retry", retry, 4'd0);
    tick(1);
    chk("clr_rst", state, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
